// File: rtl/playfield_vram_arbiter.sv
// Playfield tile RAM arbiter: display scan reads, buffered game writes, field clear.
// Ports: clk/reset_n, SVGA row/col/blank in, wr_* game write handshake, clear_req/clear_busy,
//        ram_* single-port synchronous RAM bus, pix_valid/pix_color to the colour mux.
module playfield_vram_arbiter #(
    parameter int           FIFO_DEPTH = 4,
    parameter int           FIELD_ROW0 = 50,
    parameter int           FIELD_COL0 = 300,
    parameter int           TILE_H     = 25,
    parameter int           TILE_W     = 20,
    parameter int           FIELD_ROWS = 20,
    parameter int           FIELD_COLS = 10,
    parameter logic [2:0]   EMPTY_CODE = 3'd7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  row,
    input  logic [9:0]  col,
    input  logic        blank,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [2:0]  wr_color,
    output logic        wr_err,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [2:0]  ram_wdata,
    input  logic [2:0]  ram_rdata,
    output logic        pix_valid,
    output logic [2:0]  pix_color
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ROW_END = FIELD_ROW0 + FIELD_ROWS * TILE_H;
    localparam int COL_END = FIELD_COL0 + FIELD_COLS * TILE_W;
    localparam int CELLS   = FIELD_ROWS * FIELD_COLS;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_PEND,
        CLEAR
    } state_t;

    state_t        state;
    logic [7:0]    clear_addr;
    logic [7:0]    fifo_addr [FIFO_DEPTH];
    logic [2:0]    fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          rd1;
    logic          rd2;

    logic          in_field;
    logic [9:0]    dr;
    logic [9:0]    dc;
    logic [4:0]    ty;
    logic [3:0]    tx;
    logic [7:0]    disp_idx;
    logic [7:0]    wr_idx;
    logic          wr_ok;
    logic          fifo_full;
    logic          accept;
    logic          push;
    logic          do_rd;
    logic          do_clr;
    logic          do_pop;

    assign in_field = (row >= 10'(FIELD_ROW0)) && (row < 10'(ROW_END))
                   && (col >= 10'(FIELD_COL0)) && (col < 10'(COL_END))
                   && !blank;

    assign dr = row - 10'(FIELD_ROW0);
    assign dc = col - 10'(FIELD_COL0);

    // Division by the tile size as a chain of constant compares.
    always_comb begin
        ty = '0;
        for (int i = 1; i < FIELD_ROWS; i++)
            if (dr >= 10'(i * TILE_H)) ty = 5'(i);
    end

    always_comb begin
        tx = '0;
        for (int i = 1; i < FIELD_COLS; i++)
            if (dc >= 10'(i * TILE_W)) tx = 4'(i);
    end

    assign disp_idx = 8'(ty) * 8'(FIELD_COLS) + 8'(tx);
    assign wr_idx   = 8'(wr_y) * 8'(FIELD_COLS) + 8'(wr_x);
    assign wr_ok    = (wr_x < 4'(FIELD_COLS)) && (wr_y < 5'(FIELD_ROWS));

    assign clear_busy = (state != IDLE);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_ready   = !fifo_full && !clear_busy;
    assign accept     = wr_valid && wr_ready;
    assign push       = accept && wr_ok;

    // Slot owner: display, then clear, then FIFO drain (allowed in CLEAR_PEND).
    assign do_rd  = in_field;
    assign do_clr = !do_rd && (state == CLEAR);
    assign do_pop = !do_rd && (state != CLEAR) && (count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clear_addr <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            rd1        <= 1'b0;
            rd2        <= 1'b0;
            pix_valid  <= 1'b0;
            pix_color  <= EMPTY_CODE;
            wr_err     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            unique case (1'b1)
                do_rd: begin
                    ram_addr <= disp_idx;
                    ram_we   <= 1'b0;
                end
                do_clr: begin
                    ram_addr  <= clear_addr;
                    ram_we    <= 1'b1;
                    ram_wdata <= EMPTY_CODE;
                end
                do_pop: begin
                    ram_addr  <= fifo_addr[rptr];
                    ram_we    <= 1'b1;
                    ram_wdata <= fifo_data[rptr];
                end
                default: ram_we <= 1'b0;
            endcase

            if (push) begin
                fifo_addr[wptr] <= wr_idx;
                fifo_data[wptr] <= wr_color;
                wptr            <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);

            wr_err <= accept && !wr_ok;

            // Read tag follows the slot until RAM data is valid.
            rd1       <= do_rd;
            rd2       <= rd1;
            pix_valid <= rd2;
            pix_color <= rd2 ? ram_rdata : EMPTY_CODE;

            unique case (state)
                IDLE: begin
                    if (clear_req) state <= CLEAR_PEND;
                end
                CLEAR_PEND: begin
                    if (count == '0) begin
                        state      <= CLEAR;
                        clear_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (do_clr) begin
                        if (clear_addr == 8'(CELLS - 1)) begin
                            state      <= IDLE;
                            clear_addr <= '0;
                        end else begin
                            clear_addr <= clear_addr + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
